// File: rtl/graycode_decoder_tracker.sv
// ============================================================================
//  Module      : graycode_decoder_tracker
//  Description : Gray-code receive tracker. Decodes samples to binary, tracks
//                position and faults after repeated illegal jumps.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module graycode_decoder_tracker #(
    parameter int WIDTH     = 3,
    parameter int POS_WIDTH = 8,
    parameter int ERR_LIMIT = 3
) (
    input  logic                 clk,
    input  logic                 rstN,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 step_valid,
    output logic                 dir_out,
    output logic [POS_WIDTH-1:0] position,
    output logic                 err,
    output logic [7:0]           err_count,
    output logic                 locked
);

    localparam logic [3:0] c_err_limit = 4'(ERR_LIMIT);

    typedef enum logic [1:0] {
        S_ACQUIRE = 2'd0,
        S_TRACK   = 2'd1,
        S_FAULT   = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [WIDTH-1:0]     r_bin, w_bin_nxt;
    logic [POS_WIDTH-1:0] r_pos, w_pos_nxt;
    logic                 r_dir, w_dir_nxt;
    logic                 r_step, w_step_nxt;
    logic                 r_err, w_err_nxt;
    logic [7:0]           r_errc, w_errc_nxt;
    logic [3:0]           r_consec, w_consec_nxt;
    logic                 r_locked;

    logic [WIDTH-1:0]     w_bin;
    logic [WIDTH-1:0]     w_diff;
    logic [3:0]           w_consec_inc;

    assign w_bin[WIDTH-1] = gray_in[WIDTH-1];
    for (genvar i = WIDTH - 2; i >= 0; i--) begin : g_g2b
        assign w_bin[i] = w_bin[i+1] ^ gray_in[i];
    end

    // r_bin doubles as the previous-sample reference for classification
    assign w_diff       = w_bin - r_bin;
    assign w_consec_inc = r_consec + 4'd1;

    always_comb begin
        w_state_nxt  = r_state;
        w_bin_nxt    = r_bin;
        w_pos_nxt    = r_pos;
        w_dir_nxt    = r_dir;
        w_step_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        w_errc_nxt   = r_errc;
        w_consec_nxt = r_consec;

        if (clear) begin
            w_state_nxt  = S_ACQUIRE;
            w_bin_nxt    = '0;
            w_pos_nxt    = '0;
            w_dir_nxt    = 1'b0;
            w_errc_nxt   = 8'd0;
            w_consec_nxt = 4'd0;
        end else if (sample_valid) begin
            case (r_state)
                S_ACQUIRE: begin
                    w_bin_nxt   = w_bin;
                    w_pos_nxt   = '0;
                    w_state_nxt = S_TRACK;
                end
                S_TRACK: begin
                    if (w_diff == WIDTH'(1)) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b0;
                        w_pos_nxt    = r_pos + POS_WIDTH'(1);
                        w_consec_nxt = 4'd0;
                        w_bin_nxt    = w_bin;
                    end else if (w_diff == {WIDTH{1'b1}}) begin
                        w_step_nxt   = 1'b1;
                        w_dir_nxt    = 1'b1;
                        w_pos_nxt    = r_pos - POS_WIDTH'(1);
                        w_consec_nxt = 4'd0;
                        w_bin_nxt    = w_bin;
                    end else if (w_diff != '0) begin
                        w_err_nxt    = 1'b1;
                        w_bin_nxt    = w_bin;
                        w_consec_nxt = w_consec_inc;
                        if (r_errc != 8'hFF) begin
                            w_errc_nxt = r_errc + 8'd1;
                        end
                        if (w_consec_inc >= c_err_limit) begin
                            w_state_nxt = S_FAULT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state  <= S_ACQUIRE;
            r_bin    <= '0;
            r_pos    <= '0;
            r_dir    <= 1'b0;
            r_step   <= 1'b0;
            r_err    <= 1'b0;
            r_errc   <= 8'd0;
            r_consec <= 4'd0;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bin    <= w_bin_nxt;
            r_pos    <= w_pos_nxt;
            r_dir    <= w_dir_nxt;
            r_step   <= w_step_nxt;
            r_err    <= w_err_nxt;
            r_errc   <= w_errc_nxt;
            r_consec <= w_consec_nxt;
            r_locked <= (w_state_nxt == S_TRACK);
        end
    end

    assign bin_out    = r_bin;
    assign step_valid = r_step;
    assign dir_out    = r_dir;
    assign position   = r_pos;
    assign err        = r_err;
    assign err_count  = r_errc;
    assign locked     = r_locked;

endmodule

`default_nettype wire

// File: tb/tb_graycode_decoder_tracker.sv
// ============================================================================
//  Module      : tb_graycode_decoder_tracker
//  Description : Scoreboard bench for graycode_decoder_tracker, directed vectors.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_graycode_decoder_tracker;

    logic       clk = 1'b0;
    logic       rstN;
    logic       sample_valid;
    logic [2:0] gray_in;
    logic       clear;
    logic [2:0] bin_out;
    logic       step_valid;
    logic       dir_out;
    logic [7:0] position;
    logic       err;
    logic [7:0] err_count;
    logic       locked;

    graycode_decoder_tracker #(
        .WIDTH     (3),
        .POS_WIDTH (8),
        .ERR_LIMIT (3)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .sample_valid (sample_valid),
        .gray_in      (gray_in),
        .clear        (clear),
        .bin_out      (bin_out),
        .step_valid   (step_valid),
        .dir_out      (dir_out),
        .position     (position),
        .err          (err),
        .err_count    (err_count),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] bin;
        logic       step;
        logic       dir;
        logic [7:0] pos;
        logic       err;
        logic [7:0] errc;
        logic       lk;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_vec  = 0;
    int    n_miss = 0;

    function automatic exp_t actual();
        return '{bin_out, step_valid, dir_out, position, err, err_count, locked};
    endfunction

    task automatic compare(input string name, input exp_t e);
        exp_t a;
        a = actual();
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got bin=%0d step=%0b dir=%0b pos=%0d err=%0b errc=%0d lk=%0b, want bin=%0d step=%0b dir=%0b pos=%0d err=%0b errc=%0d lk=%0b",
                     name, a.bin, a.step, a.dir, a.pos, a.err, a.errc, a.lk,
                     e.bin, e.step, e.dir, e.pos, e.err, e.errc, e.lk);
        end
    endtask

    // Monitor: one queued expectation per driven cycle, checked after the edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                compare(name_q.pop_front(), exp_q.pop_front());
            end
        end
    end

    task automatic vec(input string name, input logic v, input logic c, input logic [2:0] g,
                       input logic [2:0] b, input logic st, input logic d, input logic [7:0] p,
                       input logic e, input logic [7:0] ec, input logic lk);
        @(negedge clk);
        sample_valid = v;
        clear        = c;
        gray_in      = g;
        exp_q.push_back('{b, st, d, p, e, ec, lk});
        name_q.push_back(name);
    endtask

    task automatic quiet();
        @(negedge clk);
        sample_valid = 1'b0;
        clear        = 1'b0;
        gray_in      = 3'b000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN         = 1'b0;
        sample_valid = 1'b0;
        clear        = 1'b0;
        gray_in      = 3'b000;
        #12;
        compare("reset_state", '0);
        @(negedge clk);
        rstN = 1'b1;

        // Full up cycle including the 100 -> 000 wrap
        vec("acq_000",  1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        vec("up_001",   1, 0, 3'b001, 1, 1, 0, 1, 0, 0, 1);
        vec("up_011",   1, 0, 3'b011, 2, 1, 0, 2, 0, 0, 1);
        vec("up_010",   1, 0, 3'b010, 3, 1, 0, 3, 0, 0, 1);
        vec("up_110",   1, 0, 3'b110, 4, 1, 0, 4, 0, 0, 1);
        vec("up_111",   1, 0, 3'b111, 5, 1, 0, 5, 0, 0, 1);
        vec("up_101",   1, 0, 3'b101, 6, 1, 0, 6, 0, 0, 1);
        vec("up_100",   1, 0, 3'b100, 7, 1, 0, 7, 0, 0, 1);
        vec("up_wrap",  1, 0, 3'b000, 0, 1, 0, 8, 0, 0, 1);
        vec("idle",     0, 0, 3'b011, 0, 0, 0, 8, 0, 0, 1);
        vec("hold",     1, 0, 3'b000, 0, 0, 0, 8, 0, 0, 1);

        // Clear discards its sample; down steps wrap position below zero
        vec("clear1",   1, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0);
        vec("acq2",     1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        vec("dn_100",   1, 0, 3'b100, 7, 1, 1, 255, 0, 0, 1);
        vec("dn_101",   1, 0, 3'b101, 6, 1, 1, 254, 0, 0, 1);
        vec("dn_111",   1, 0, 3'b111, 5, 1, 1, 253, 0, 0, 1);

        // Illegal jump, then a legal step resets the consecutive count
        vec("clear2",   0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        vec("acq3",     1, 0, 3'b001, 1, 0, 0, 0, 0, 0, 1);
        vec("ill_010",  1, 0, 3'b010, 3, 0, 0, 0, 1, 1, 1);
        vec("up_after", 1, 0, 3'b110, 4, 1, 0, 1, 0, 1, 1);
        vec("ill_a",    1, 0, 3'b000, 0, 0, 0, 1, 1, 2, 1);
        vec("ill_b",    1, 0, 3'b110, 4, 0, 0, 1, 1, 3, 1);

        // Three consecutive illegal jumps force FAULT
        vec("clear3",   0, 1, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        vec("acq4",     1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        vec("f_ill1",   1, 0, 3'b010, 3, 0, 0, 0, 1, 1, 1);
        vec("f_ill2",   1, 0, 3'b000, 0, 0, 0, 0, 1, 2, 1);
        vec("f_ill3",   1, 0, 3'b010, 3, 0, 0, 0, 1, 3, 0);
        vec("f_ignore", 1, 0, 3'b110, 3, 0, 0, 0, 0, 3, 0);
        vec("f_ign2",   1, 0, 3'b111, 3, 0, 0, 0, 0, 3, 0);

        // Clear out of FAULT with a simultaneous sample, then re-acquire
        vec("f_clear",  1, 1, 3'b001, 0, 0, 0, 0, 0, 0, 0);
        vec("acq5",     1, 0, 3'b011, 2, 0, 0, 0, 0, 0, 1);
        vec("p1",       1, 0, 3'b010, 3, 1, 0, 1, 0, 0, 1);
        vec("p2",       1, 0, 3'b110, 4, 1, 0, 2, 0, 0, 1);
        vec("p3",       1, 0, 3'b111, 5, 1, 0, 3, 0, 0, 1);
        vec("p4",       1, 0, 3'b101, 6, 1, 0, 4, 0, 0, 1);
        vec("p5",       1, 0, 3'b100, 7, 1, 0, 5, 0, 0, 1);
        quiet();

        // Asynchronous reset pulse between clock edges
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        compare("async_reset", '0);
        rstN = 1'b1;
        vec("post_rst", 0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0);
        vec("acq6",     1, 0, 3'b000, 0, 0, 0, 0, 0, 0, 1);
        quiet();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
